// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared op encodings, FSM states and width helpers for the MDU.
//  Revision : 1.0
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int XLEN_DEFAULT = 32;
    localparam int CNT_W        = $clog2(XLEN_DEFAULT) + 1;

    // Counter width for an arbitrary operand width.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divcore.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_divcore
//  Purpose  : Restoring radix-2 divider datapath on unsigned magnitudes,
//             stepped one quotient bit per cycle by the parent FSM.
//  Revision : 1.0
// ============================================================================
module mdu_divcore #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo_next,
    output logic [XLEN-1:0] o_rem_next
);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dsr;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;

    // The partial remainder stays below the divisor, so the shifted value
    // always fits in XLEN+1 bits and the borrow bit decides the quotient bit.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_dsr};
        if (!w_diff[XLEN]) begin
            o_rem_next = w_diff[XLEN-1:0];
            o_quo_next = {r_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem_next = w_rem_sh[XLEN-1:0];
            o_quo_next = {r_quo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dsr <= i_divisor;
        end else if (i_step) begin
            r_quo <= o_quo_next;
            r_rem <= o_rem_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : stage_e_mdu
//  Purpose  : Iterative multiply/divide unit for the execute stage (RV32M
//             plus ARM MUL/MLA) with stall request and one-cycle done pulse.
//  Revision : 1.0
// ============================================================================
module stage_e_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic [2:0]      MdOpE,
    input  logic            armE,
    input  logic            AccE,
    input  logic [XLEN-1:0] Op1E,
    input  logic [XLEN-1:0] Op2E,
    input  logic [XLEN-1:0] Op3E,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] MdResultE
);

    localparam int                 C_CNT_W    = cnt_width(XLEN);
    localparam logic [C_CNT_W-1:0] C_N_MUL    = C_CNT_W'(XLEN / MUL_STEP);
    localparam logic [C_CNT_W-1:0] C_N_DIV    = C_CNT_W'(XLEN);
    localparam logic [XLEN-1:0]    C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t          r_state;
    mdu_state_t          w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt;
    md_op_t              r_op;
    logic                r_acc;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_op3;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_is_div;
    logic                w_sgn1;
    logic                w_sgn2;
    logic                w_neg1;
    logic                w_neg2;
    logic [XLEN-1:0]     w_abs1;
    logic [XLEN-1:0]     w_abs2;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [2*XLEN-1:0]   w_partial;
    logic [2*XLEN-1:0]   w_prod_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN-1:0]     w_quo_next;
    logic [XLEN-1:0]     w_rem_next;
    logic [XLEN-1:0]     w_div_res;

    assign w_accept  = (r_state == IDLE) && StartE && !FlushE;
    assign w_last    = (r_state == RUN) && !FlushE && (r_cnt == C_CNT_W'(1));
    assign MdResultE = r_result;

    // Operand signedness, magnitudes and the zero-iteration special cases.
    always_comb begin
        w_is_div      = MdOpE[2];
        w_sgn1        = w_is_div ? !MdOpE[0] : (armE || MdOpE != 3'b011);
        w_sgn2        = w_is_div ? !MdOpE[0] : (armE || !MdOpE[1]);
        w_neg1        = w_sgn1 && Op1E[XLEN-1];
        w_neg2        = w_sgn2 && Op2E[XLEN-1];
        w_abs1        = w_neg1 ? -Op1E : Op1E;
        w_abs2        = w_neg2 ? -Op2E : Op2E;
        w_special     = 1'b1;
        w_special_res = '0;
        if (armE && MdOpE != 3'b000) begin
            w_special_res = '0;
        end else if (w_is_div && Op2E == '0) begin
            w_special_res = MdOpE[1] ? Op1E : '1;
        end else if (w_is_div && w_sgn1 && Op1E == C_MOST_NEG && (&Op2E)) begin
            w_special_res = MdOpE[1] ? '0 : Op1E;
        end else begin
            w_special = 1'b0;
        end
    end

    // Shift-add multiplier step and the sign/select fix-up for the last step.
    always_comb begin
        w_partial = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (r_mplier[k]) begin
                w_partial = w_partial + (r_mcand << k);
            end
        end
        w_prod_next = r_prod + w_partial;
        w_prod_fix  = r_neg_q ? -w_prod_next : w_prod_next;
        if (r_op[1:0] != 2'b00) begin
            w_mul_res = w_prod_fix[2*XLEN-1:XLEN];
        end else begin
            w_mul_res = w_prod_fix[XLEN-1:0] + (r_acc ? r_op3 : '0);
        end
        if (r_op[1]) begin
            w_div_res = r_neg_r ? -w_rem_next : w_rem_next;
        end else begin
            w_div_res = r_neg_q ? -w_quo_next : w_quo_next;
        end
    end

    mdu_divcore #(
        .XLEN (XLEN)
    ) u_divcore (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     ((r_state == RUN) && r_op[2] && !FlushE),
        .i_dividend (w_abs1),
        .i_divisor  (w_abs2),
        .o_quo_next (w_quo_next),
        .o_rem_next (w_rem_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BusyE       = 1'b0;
        DoneE       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    BusyE       = 1'b1;
                    w_state_nxt = w_special ? DONE : RUN;
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (FlushE) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                DoneE       = !FlushE;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_op     <= MD_MUL;
            r_acc    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op3    <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= md_op_t'(MdOpE);
            r_acc    <= armE && AccE;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_op3    <= Op3E;
            r_mplier <= w_abs2;
            r_mcand  <= {{XLEN{1'b0}}, w_abs1};
            r_prod   <= '0;
            if (w_special) begin
                r_cnt    <= '0;
                r_result <= w_special_res;
            end else begin
                r_cnt <= w_is_div ? C_N_DIV : C_N_MUL;
            end
        end else if (r_state == RUN) begin
            if (FlushE) begin
                r_cnt <= '0;
            end else begin
                r_cnt    <= r_cnt - C_CNT_W'(1);
                r_mplier <= r_mplier >> MUL_STEP;
                r_mcand  <= r_mcand << MUL_STEP;
                r_prod   <= w_prod_next;
                if (w_last) begin
                    r_result <= r_op[2] ? w_div_res : w_mul_res;
                end
            end
        end
    end

endmodule
`default_nettype wire
